// File: rtl/tas_pkt_tx.sv
// Serial packet transmitter: shifts out header + four temperature bytes LSB first, data_ena framing each byte.
// Latency: first bit one cycle after accept; pkt_done at accept + 1 + (40 + 4*BYTE_GAP_BITS + PKT_GAP_BITS)*CLKS_PER_BIT.
// Backpressure: pkt_ready only in IDLE; inputs are ignored while a packet is in flight.
//
// Ports:
//   clk_50, reset      : clock (posedge) and asynchronous active-high reset
//   pkt_valid/ready    : packet handshake; pkt_header + pkt_temp latched on accept
//   serial_data        : serial bit, LSB first, zero outside byte windows
//   data_ena           : high for the 8 bit-times of each byte
//   busy               : packet in flight (cycle after accept through last PKT_GAP cycle)
//   pkt_done           : one-cycle pulse on the first IDLE cycle after a packet
//   exp_avg            : (t0+t1+t2+t3)>>2 of the last accepted packet
module tas_pkt_tx #(
  parameter int CLKS_PER_BIT  = 1,
  parameter int BYTE_GAP_BITS = 2,
  parameter int PKT_GAP_BITS  = 4
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [7:0]  pkt_header,
  input  logic [31:0] pkt_temp,
  output logic        serial_data,
  output logic        data_ena,
  output logic        busy,
  output logic        pkt_done,
  output logic [7:0]  exp_avg
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND_BIT = 2'd1;
  localparam logic [1:0] BYTE_GAP = 2'd2;
  localparam logic [1:0] PKT_GAP  = 2'd3;

  localparam logic [7:0]  BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BGAP_LAST = 16'(BYTE_GAP_BITS - 1);
  localparam logic [15:0] PGAP_LAST = 16'(PKT_GAP_BITS - 1);

  logic [1:0]  state;
  logic [7:0]  baud_cnt;
  logic [2:0]  bit_idx;
  logic [2:0]  byte_idx;
  logic [15:0] gap_cnt;
  logic [39:0] shift_buf;
  logic        out_of_reset;
  logic        accept;
  logic        baud_last;
  logic [9:0]  temp_sum;

  // Ready is held low until the first clock after reset release.
  assign pkt_ready   = out_of_reset && (state == IDLE);
  assign accept      = pkt_valid && pkt_ready;
  assign busy        = (state != IDLE);
  assign data_ena    = (state == SEND_BIT);
  // The current bit always sits at the bottom of the shift buffer.
  assign serial_data = data_ena && shift_buf[0];
  assign baud_last   = (baud_cnt == BAUD_LAST);

  // Ten bits hold the sum of four bytes without overflow.
  assign temp_sum = {2'b00, pkt_temp[7:0]}   + {2'b00, pkt_temp[15:8]} +
                    {2'b00, pkt_temp[23:16]} + {2'b00, pkt_temp[31:24]};

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      gap_cnt      <= '0;
      shift_buf    <= '0;
      out_of_reset <= 1'b0;
      pkt_done     <= 1'b0;
      exp_avg      <= '0;
    end else begin
      out_of_reset <= 1'b1;
      pkt_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            // Wire order header, t0..t3 falls out of shifting right from bit 0.
            shift_buf <= {pkt_temp, pkt_header};
            exp_avg   <= temp_sum[9:2];
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            state     <= SEND_BIT;
          end
        end

        SEND_BIT: begin
          if (baud_last) begin
            baud_cnt  <= '0;
            shift_buf <= {1'b0, shift_buf[39:1]};
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              gap_cnt <= '0;
              state   <= (byte_idx == 3'd4) ? PKT_GAP : BYTE_GAP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end

        BYTE_GAP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (gap_cnt == BGAP_LAST) begin
              byte_idx <= byte_idx + 3'd1;
              state    <= SEND_BIT;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end

        PKT_GAP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (gap_cnt == PGAP_LAST) begin
              state    <= IDLE;
              pkt_done <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tas_pkt_tx.sv
// Testbench for tas_pkt_tx: two instances (CLKS_PER_BIT 1 and 3) driven with directed and random packets.
// A per-instance reference builds the expected wire waveform, pkt_done cycle and average on each accept.
// Monitors compare every cycle at the falling edge; inputs change 1 time unit after the rising edge.
module tb_tas_pkt_tx;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        valid;
  logic [1:0][7:0]   hdr;
  logic [1:0][31:0]  temp;
  logic [1:0]        rdy, sd, de, bz, dn;
  logic [1:0][7:0]   avg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic up;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tracks "at least one clock seen since reset release".
  always @(posedge clk or posedge rst) begin
    if (rst) up <= 1'b0;
    else     up <= 1'b1;
  end

  tas_pkt_tx u0 (
    .clk_50(clk), .reset(rst), .pkt_valid(valid[0]), .pkt_ready(rdy[0]),
    .pkt_header(hdr[0]), .pkt_temp(temp[0]), .serial_data(sd[0]),
    .data_ena(de[0]), .busy(bz[0]), .pkt_done(dn[0]), .exp_avg(avg[0])
  );

  tas_pkt_tx #(.CLKS_PER_BIT(3)) u1 (
    .clk_50(clk), .reset(rst), .pkt_valid(valid[1]), .pkt_ready(rdy[1]),
    .pkt_header(hdr[1]), .pkt_temp(temp[1]), .serial_data(sd[1]),
    .data_ena(de[1]), .busy(bz[1]), .pkt_done(dn[1]), .exp_avg(avg[1])
  );

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: on every accept, expand the packet into one (data_ena, serial_data)
  // entry per clock using the documented byte order and gap lengths.
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int CPB = (g == 0) ? 1 : 3;
    logic [1:0] wq[$];
    int         dq[$];
    int         mavg = 0;

    always @(negedge clk) begin
      logic [1:0] e;
      logic       exp_done;
      logic [7:0] b[5];
      int         s;
      if (rst) begin
        check($sformatf("u%0d rst pkt_ready", g), rdy[g], 1'b0);
        check($sformatf("u%0d rst data_ena", g), de[g], 1'b0);
        check($sformatf("u%0d rst serial_data", g), sd[g], 1'b0);
        check($sformatf("u%0d rst busy", g), bz[g], 1'b0);
        check($sformatf("u%0d rst pkt_done", g), dn[g], 1'b0);
        check($sformatf("u%0d rst exp_avg", g), avg[g], 8'h00);
        wq.delete();
        dq.delete();
        mavg = 0;
      end else begin
        check($sformatf("u%0d pkt_ready", g), rdy[g], up && (wq.size() == 0));
        check($sformatf("u%0d exp_avg", g), avg[g], mavg[7:0]);
        exp_done = (dq.size() > 0) && (dq[0] == cyc);
        if (exp_done) void'(dq.pop_front());
        check($sformatf("u%0d pkt_done", g), dn[g], exp_done);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          check($sformatf("u%0d data_ena", g), de[g], e[1]);
          check($sformatf("u%0d serial_data", g), sd[g], e[0]);
          check($sformatf("u%0d busy", g), bz[g], 1'b1);
        end else begin
          check($sformatf("u%0d idle data_ena", g), de[g], 1'b0);
          check($sformatf("u%0d idle serial_data", g), sd[g], 1'b0);
          check($sformatf("u%0d idle busy", g), bz[g], 1'b0);
        end
        // Accept happens at the coming rising edge.
        if (valid[g] && rdy[g]) begin
          b[0] = hdr[g];
          s = 0;
          for (int i = 1; i < 5; i++) begin
            b[i] = temp[g][8*(i-1) +: 8];
            s += int'(b[i]);
          end
          mavg = s / 4;
          for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 8; j++)
              for (int c = 0; c < CPB; c++) wq.push_back({1'b1, b[i][j]});
            for (int c = 0; c < ((i < 4) ? 2 : 4) * CPB; c++) wq.push_back(2'b00);
          end
          dq.push_back(cyc + 1 + wq.size());
        end
      end
    end
  end

  // Offer a packet; returns 1 time unit after the accept edge.
  task automatic send(input int k, input logic [7:0] h, input logic [31:0] t, input bit hold);
    int n;
    valid[k] = 1'b1;
    hdr[k]   = h;
    temp[k]  = t;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy[k]) break;
      n++;
      if (n > 2000) begin
        check($sformatf("u%0d accept timeout", k), 1'b1, 1'b0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      valid[k] = 1'b0;
      hdr[k]   = 8'($urandom);
      temp[k]  = $urandom;
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy[k]) break;
      n++;
      if (n > 2000) begin
        check($sformatf("u%0d idle timeout", k), 1'b1, 1'b0);
        break;
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    valid = '0;
    hdr   = '0;
    temp  = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed: A5 with 10,20,30,40 -> average 25.
    send(0, 8'hA5, {8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);
    wait_idle(0);
    check("u0 avg 10..40", avg[0], 8'h19);

    // Three clocks per bit, all-FF temps: average FF, no overflow.
    send(1, 8'hC3, 32'hFFFF_FFFF, 1'b0);
    wait_idle(1);
    check("u1 avg all FF", avg[1], 8'hFF);

    // Back-to-back with pkt_valid held high.
    send(0, 8'h3C, 32'h0102_0304, 1'b1);
    send(0, 8'hE7, 32'h8040_2010, 1'b0);
    wait_idle(0);

    // Poke inputs while busy: must be ignored.
    send(0, 8'h96, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      valid[0] = 1'($urandom);
      hdr[0]   = 8'($urandom);
      temp[0]  = $urandom;
    end
    valid[0] = 1'b0;
    wait_idle(0);

    // Random traffic on both instances concurrently.
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send(0, 8'($urandom), $urandom, (i < 11) ? 1'($urandom) : 1'b0);
          if (!valid[0]) repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
      begin
        for (int i = 0; i < 4; i++) begin
          send(1, 8'($urandom), $urandom, (i < 3) ? 1'($urandom) : 1'b0);
          if (!valid[1]) repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
    join
    wait_idle(0);
    wait_idle(1);

    // Reset during byte 2, bit 4 (cycle 25 after accept).
    send(0, 8'h81, 32'h5566_7788, 1'b0);
    repeat (24) @(posedge clk);
    #2;
    check("pre-reset data_ena", de[0], 1'b1);
    rst = 1'b1;
    #1;
    check("async data_ena", de[0], 1'b0);
    check("async serial_data", sd[0], 1'b0);
    check("async busy", bz[0], 1'b0);
    check("async pkt_ready", rdy[0], 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post-reset pkt_ready", rdy[0], 1'b1);

    // Fresh packet after reset starts from header bit 0.
    send(0, 8'h5A, {8'd64, 8'd64, 8'd64, 8'd64}, 1'b0);
    wait_idle(0);
    check("u0 avg 64s", avg[0], 8'h40);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
